// File: rtl/mmio_console_pkg.sv
// Shared constants for the MMIO console: register offsets, STATUS layout,
// drain FSM state type and the console window decode helper.
package mmio_console_pkg;

    // Register offsets relative to BASE (12-bit window)
    localparam logic [11:0] OFF_HALT   = 12'h000;
    localparam logic [11:0] OFF_CON    = 12'h100;
    localparam logic [11:0] OFF_WDT_LO = 12'h200;
    localparam logic [11:0] OFF_WDT_HI = 12'h204;
    localparam logic [11:0] OFF_STATUS = 12'h208;
    localparam logic [11:0] OFF_CYC_LO = 12'h20C;
    localparam logic [11:0] OFF_CYC_HI = 12'h210;

    // STATUS register field positions
    localparam int ST_HALT      = 0;
    localparam int ST_TIMEOUT   = 1;
    localparam int ST_COUNT_LSB = 2;
    localparam int ST_COUNT_W   = 6;
    localparam int ST_DROP_LSB  = 8;
    localparam int ST_DROP_W    = 8;

    // Drain FSM: IDLE waits for data, PRESENT holds a byte on the tx port
    typedef enum logic {
        DRAIN_IDLE    = 1'b0,
        DRAIN_PRESENT = 1'b1
    } drain_state_e;

    // True for a word-aligned CONSOLE[c] offset with c < nch
    function automatic logic is_console(input logic [11:0] off, input int nch);
        return (off[11:6] == OFF_CON[11:6]) && (off[1:0] == 2'b00) &&
               ({28'b0, off[5:2]} < nch);
    endfunction

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Single-clock FIFO with full/empty/count and same-cycle push/pop.
// A push into a full FIFO is accepted when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Accepted push/pop and pointer/count next state
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_console.sv
// MMIO console / halt / watchdog peripheral. Decodes the bus, queues tagged
// console bytes in a FIFO and drains them to the UART over WE/DATA/READY.
// The byte on the wire stays in the FIFO until tx_ready accepts it, so
// fifo_count always includes the byte currently being presented.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'hf0000000,
    parameter int          NCH        = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CYC_W      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_oe,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mmio_rdata,
    output logic        tx_we,
    output logic [7:0]  tx_data,
    output logic [3:0]  tx_ch,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        timeout
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [11:0]      off;
    logic             in_range, wr_en, rd_en, con_hit;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, drop_ev;
    logic [11:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status;
    logic [63:0]      cyc64, lim64;

    logic             halt_q, halt_d, timeout_q, timeout_d;
    logic [31:0]      halt_code_q, halt_code_d, rdata_q, rdata_d;
    logic [CYC_W-1:0] cycle_q, cycle_d, limit_q, limit_d;
    logic [7:0]       drop_q, drop_d, tx_data_q, tx_data_d;
    logic [3:0]       tx_ch_q, tx_ch_d;
    drain_state_e     state_q, state_d;

    assign off       = mem_addr[11:0];
    assign in_range  = mmio_oe && (mem_addr[31:12] == BASE[31:12]);
    assign wr_en     = in_range && mmio_we[0];
    assign rd_en     = in_range && !mmio_we[0];
    assign con_hit   = is_console(off, NCH);
    assign fifo_push = wr_en && con_hit && !halt_q;
    assign drop_ev   = fifo_push && fifo_full && !fifo_pop;
    assign cyc64     = 64'(cycle_q);

    sync_fifo #(.W(12), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i ({off[5:2], mem_wdata[7:0]}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // STATUS word assembly
    always_comb begin
        status = '0;
        status[ST_HALT]                       = halt_q;
        status[ST_TIMEOUT]                    = timeout_q;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
        status[ST_DROP_LSB +: ST_DROP_W]      = drop_q;
    end

    // Register writes, watchdog, drop counter and registered read mux
    always_comb begin
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        drop_d      = drop_q;
        cycle_d     = cycle_q + CYC_W'(1);
        timeout_d   = timeout_q || ((limit_q != '0) && (cycle_q > limit_q));
        lim64       = 64'(limit_q);
        rdata_d     = '0;

        if (wr_en && off == OFF_HALT && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = mem_wdata;
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en && mmio_we[b] && off == OFF_WDT_LO) lim64[8*b +: 8]      = mem_wdata[8*b +: 8];
            if (wr_en && mmio_we[b] && off == OFF_WDT_HI) lim64[32+8*b +: 8]   = mem_wdata[8*b +: 8];
        end
        limit_d = lim64[CYC_W-1:0];
        if (drop_ev && drop_q != 8'hff) drop_d = drop_q + 8'd1;

        if (rd_en) begin
            if (con_hit) rdata_d = {31'b0, !fifo_full};
            else begin
                case (off)
                    OFF_WDT_LO: rdata_d = lim64[31:0];
                    OFF_WDT_HI: rdata_d = lim64[63:32];
                    OFF_STATUS: rdata_d = status;
                    OFF_CYC_LO: rdata_d = cyc64[31:0];
                    OFF_CYC_HI: rdata_d = cyc64[63:32];
                    default:    rdata_d = '0;
                endcase
            end
        end
    end

    // Drain FSM: latch the head, present it, pop it once accepted
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_ch_d   = tx_ch_q;
        fifo_pop  = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (!fifo_empty) begin
                    tx_data_d = fifo_rdata[7:0];
                    tx_ch_d   = fifo_rdata[11:8];
                    state_d   = DRAIN_PRESENT;
                end
            end
            DRAIN_PRESENT: begin
                if (tx_ready) begin
                    fifo_pop = 1'b1;
                    state_d  = DRAIN_IDLE;
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            timeout_q   <= 1'b0;
            cycle_q     <= '0;
            limit_q     <= '0;
            drop_q      <= '0;
            rdata_q     <= '0;
            tx_data_q   <= '0;
            tx_ch_q     <= '0;
            state_q     <= DRAIN_IDLE;
        end else begin
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            timeout_q   <= timeout_d;
            cycle_q     <= cycle_d;
            limit_q     <= limit_d;
            drop_q      <= drop_d;
            rdata_q     <= rdata_d;
            tx_data_q   <= tx_data_d;
            tx_ch_q     <= tx_ch_d;
            state_q     <= state_d;
        end
    end

    assign mmio_rdata = rdata_q;
    assign tx_we      = (state_q == DRAIN_PRESENT);
    assign tx_data    = tx_data_q;
    assign tx_ch      = tx_ch_q;
    assign halt       = halt_q;
    assign halt_code  = halt_code_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: scenario tasks with inline comparisons, a
// negedge monitor scoring tx handshakes against an expected byte queue.
`timescale 1ns/1ps
module tb_mmio_console;
    localparam logic [31:0] BASE     = 32'hf0000000;
    localparam int          NCH      = 4;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] A_HALT   = BASE + 32'h000;
    localparam logic [31:0] A_CON0   = BASE + 32'h100;
    localparam logic [31:0] A_WDT_LO = BASE + 32'h200;
    localparam logic [31:0] A_WDT_HI = BASE + 32'h204;
    localparam logic [31:0] A_STATUS = BASE + 32'h208;
    localparam logic [31:0] A_CYC_LO = BASE + 32'h20C;
    localparam logic [31:0] A_CYC_HI = BASE + 32'h210;

    logic        clk = 1'b0, rst = 1'b1, mmio_oe = 1'b0, tx_ready = 1'b0;
    logic [3:0]  mmio_we = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [31:0] mmio_rdata, halt_code;
    logic        tx_we, halt, timeout;
    logic [7:0]  tx_data;
    logic [3:0]  tx_ch;

    int          n_checks = 0, n_pass = 0, n_emitted = 0, tb_cyc = 0, last_wr_cyc = 0;
    logic [11:0] exp_q[$];
    int          hs_cyc_q[$];
    logic [11:0] mon_e;
    bit          rand_ready_en = 1'b0;

    mmio_console #(.BASE(BASE), .NCH(NCH), .FIFO_DEPTH(DEPTH), .CYC_W(64)) dut (
        .clk(clk), .rst(rst), .mmio_oe(mmio_oe), .mmio_we(mmio_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mmio_rdata(mmio_rdata), .tx_we(tx_we), .tx_data(tx_data),
        .tx_ch(tx_ch), .tx_ready(tx_ready), .halt(halt), .halt_code(halt_code), .timeout(timeout)
    );

    // Clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Random transmitter back-pressure when enabled
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: every accepted byte must match the head of exp_q
    always @(negedge clk) begin
        if (!rst && tx_we === 1'b1 && tx_ready) begin
            n_checks++;
            n_emitted++;
            hs_cyc_q.push_back(tb_cyc);
            if (exp_q.size() == 0) begin
                $display("FAIL tx_unexpected: got ch=%0d data=%02h, required no byte", tx_ch, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({tx_ch, tx_data} !== mon_e)
                    $display("FAIL tx_byte: got ch=%0d data=%02h, required ch=%0d data=%02h",
                             tx_ch, tx_data, mon_e[11:8], mon_e[7:0]);
                else n_pass++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
        last_wr_cyc = tb_cyc;
        mmio_oe = 1'b1; mmio_we = 4'hf; mem_addr = a; mem_wdata = d;
        @(posedge clk); #1;
        mmio_oe = 1'b0; mmio_we = 4'h0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        mmio_oe = 1'b1; mmio_we = 4'h0; mem_addr = a;
        @(posedge clk); #1;
        mmio_oe = 1'b0; mem_addr = '0;
        d = mmio_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        ok = (exp_q.size() == 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        n_checks++; if (tx_we !== 1'b0) $display("FAIL reset_tx_we: got %b, required 0", tx_we); else n_pass++;
        n_checks++; if (halt !== 1'b0) $display("FAIL reset_halt: got %b, required 0", halt); else n_pass++;
        n_checks++; if (halt_code !== 32'h0) $display("FAIL reset_halt_code: got %h, required 0", halt_code); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b, required 0", timeout); else n_pass++;
        n_checks++; if ({tx_ch, tx_data} !== 12'h0) $display("FAIL reset_tx_bus: got %h, required 0", {tx_ch, tx_data}); else n_pass++;
        n_checks++; if (mmio_rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", mmio_rdata); else n_pass++;
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_status: got %h, required 0", rd); else n_pass++;
        mmio_read(A_CON0, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL reset_con_ready: got %h, required 1", rd); else n_pass++;
    endtask

    task automatic test_console_order();
        int s;
        bit ok;
        tx_ready = 1'b1;
        hs_cyc_q.delete();
        exp_q.push_back({4'd0, 8'h48});
        exp_q.push_back({4'd0, 8'h69});
        exp_q.push_back({4'd2, 8'h78});
        mmio_write(A_CON0, 32'h48);
        s = last_wr_cyc;
        mmio_write(A_CON0, 32'h69);
        mmio_write(A_CON0 + 32'h8, 32'h78);
        wait_drain(50, ok);
        n_checks++; if (!ok) $display("FAIL order_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (hs_cyc_q.size() != 3) $display("FAIL order_count: got %0d bytes, required 3", hs_cyc_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < hs_cyc_q.size(); i++) begin
            n_checks++;
            if (hs_cyc_q[i] != s + 2 + 2*i)
                $display("FAIL order_timing%0d: got cycle %0d, required %0d", i, hs_cyc_q[i], s + 2 + 2*i);
            else n_pass++;
        end
    endtask

    task automatic test_fifo_full_drop();
        logic [31:0] rd;
        logic [7:0]  b;
        int          e0;
        bit          ok;
        tx_ready = 1'b0;
        e0 = n_emitted;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back({4'd1, b});
            mmio_write(A_CON0 + 32'h4, {24'h0, b});
        end
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd[7:2] !== 6'd16) $display("FAIL full_count: got %0d, required 16", rd[7:2]); else n_pass++;
        n_checks++; if (rd[15:8] !== 8'd4) $display("FAIL full_drop: got %0d, required 4", rd[15:8]); else n_pass++;
        mmio_read(A_CON0 + 32'h4, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL full_con_read: got %h, required 0", rd); else n_pass++;
        tx_ready = 1'b1;
        wait_drain(100, ok);
        cycles(10);
        n_checks++; if (!ok) $display("FAIL full_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
        n_checks++; if (n_emitted - e0 != 16) $display("FAIL full_emitted: got %0d, required 16", n_emitted - e0); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        logic [31:0] rd;
        logic [7:0]  b;
        bit          ok;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            exp_q.push_back({4'd3, b});
            mmio_write(A_CON0 + 32'hC, {24'h0, b});
        end
        cycles(2);
        b = 8'($urandom);
        exp_q.push_back({4'd0, b});
        tx_ready = 1'b1;
        mmio_write(A_CON0, {24'h0, b});
        tx_ready = 1'b0;
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd[7:2] !== 6'd16) $display("FAIL pp_count: got %0d, required 16", rd[7:2]); else n_pass++;
        n_checks++; if (rd[15:8] !== 8'd4) $display("FAIL pp_drop: got %0d, required 4", rd[15:8]); else n_pass++;
        tx_ready = 1'b1;
        wait_drain(100, ok);
        n_checks++; if (!ok) $display("FAIL pp_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [7:0]  b;
        int          ch, n;
        bit          ok;
        rand_ready_en = 1'b1;
        for (int burst = 0; burst < 6; burst++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                ch = $urandom_range(0, NCH - 1);
                b  = 8'($urandom);
                exp_q.push_back({4'(ch), b});
                mmio_write(A_CON0 + 32'(4 * ch), {24'h0, b});
                cycles($urandom_range(0, 2));
            end
            // Accesses that must not enqueue anything
            mmio_write(A_CON0 + 32'h10, 32'h11);
            mmio_write(BASE + 32'h102, 32'h22);
            mmio_write(BASE + 32'h300, 32'h33);
            mmio_write(32'he0000100, 32'h44);
            wait_drain(1000, ok);
            n_checks++; if (!ok) $display("FAIL rand_drain%0d: got %0d left, required 0", burst, exp_q.size()); else n_pass++;
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #2;
        tx_ready = 1'b0;
        cycles(3);
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd !== 32'h400) $display("FAIL rand_status: got %h, required 00000400", rd); else n_pass++;
        mmio_read(BASE + 32'h300, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h, required 0", rd); else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] rd;
        int          e0;
        tx_ready = 1'b1;
        mmio_write(A_HALT, 32'h0000002a);
        n_checks++; if (halt !== 1'b1) $display("FAIL halt_set: got %b, required 1", halt); else n_pass++;
        n_checks++; if (halt_code !== 32'h2a) $display("FAIL halt_code: got %h, required 2a", halt_code); else n_pass++;
        mmio_write(A_HALT, 32'h7);
        n_checks++; if (halt_code !== 32'h2a) $display("FAIL halt_second: got %h, required 2a", halt_code); else n_pass++;
        e0 = n_emitted;
        mmio_write(A_CON0, 32'h55);
        cycles(6);
        n_checks++; if (n_emitted != e0) $display("FAIL halt_con_blocked: got %0d bytes, required 0", n_emitted - e0); else n_pass++;
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd !== 32'h401) $display("FAIL halt_status: got %h, required 00000401", rd); else n_pass++;
        mmio_write(A_WDT_HI, 32'h12345678);
        mmio_read(A_WDT_HI, rd);
        n_checks++; if (rd !== 32'h12345678) $display("FAIL halt_reg_write: got %h, required 12345678", rd); else n_pass++;
    endtask

    task automatic test_watchdog();
        logic [31:0] rd;
        // limit 0: watchdog disabled
        do_reset();
        cycles(3);
        mmio_read(A_CYC_LO, rd);
        n_checks++; if (rd !== 32'd3) $display("FAIL cycle_lo: got %0d, required 3", rd); else n_pass++;
        mmio_read(A_CYC_HI, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL cycle_hi: got %0d, required 0", rd); else n_pass++;
        cycles(5);
        mmio_write(A_WDT_LO, 32'd0);
        cycles(150);
        n_checks++; if (timeout !== 1'b0) $display("FAIL wdt_disabled: got %b, required 0", timeout); else n_pass++;
        // limit 100 written in cycle 10
        do_reset();
        cycles(10);
        mmio_write(A_WDT_LO, 32'd100);
        cycles(90);
        n_checks++; if (timeout !== 1'b0) $display("FAIL wdt_early: got %b, required 0 at cycle 101", timeout); else n_pass++;
        cycles(1);
        n_checks++; if (timeout !== 1'b1) $display("FAIL wdt_fire: got %b, required 1 at cycle 102", timeout); else n_pass++;
        mmio_read(A_WDT_LO, rd);
        n_checks++; if (rd !== 32'd100) $display("FAIL wdt_readback: got %0d, required 100", rd); else n_pass++;
        cycles(20);
        n_checks++; if (timeout !== 1'b1) $display("FAIL wdt_sticky: got %b, required 1", timeout); else n_pass++;
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] rd;
        logic [7:0]  b;
        int          e0;
        do_reset();
        tx_ready = 1'b0;
        mmio_write(A_WDT_LO, 32'd5);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back({4'd2, b});
            mmio_write(A_CON0 + 32'h8, {24'h0, b});
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 3; i++) begin @(posedge clk); #1; end
        tx_ready = 1'b0;
        mmio_write(A_HALT, 32'h9);
        cycles(3);
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd !== 32'h10f) $display("FAIL mid_status: got %h, required 0000010f", rd); else n_pass++;
        n_checks++; if (tx_we !== 1'b1) $display("FAIL mid_presenting: got %b, required 1", tx_we); else n_pass++;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        n_checks++; if (tx_we !== 1'b0) $display("FAIL mid_rst_tx_we: got %b, required 0", tx_we); else n_pass++;
        n_checks++; if (halt !== 1'b0) $display("FAIL mid_rst_halt: got %b, required 0", halt); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL mid_rst_timeout: got %b, required 0", timeout); else n_pass++;
        rst = 1'b0;
        mmio_read(A_STATUS, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL mid_rst_status: got %h, required 0", rd); else n_pass++;
        e0 = n_emitted;
        tx_ready = 1'b1;
        cycles(10);
        n_checks++; if (n_emitted != e0) $display("FAIL mid_rst_flushed: got %0d bytes, required 0", n_emitted - e0); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_console_order();
        test_fifo_full_drop();
        test_push_pop_full();
        test_random();
        test_halt();
        test_watchdog();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish before 2ms");
        $fatal(1, "time limit");
    end

endmodule
